// File: rtl/pix_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pix_rx_pkg
// Description : Shared types and helpers for the framed UART pixel receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package pix_rx_pkg;

  // Receiver frame state
  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } rx_state_t;

  // Default frame-start marker
  localparam logic [7:0] c_DEFAULT_SYNC = 8'hA5;

  // Width of the byte-within-pixel index; at least one bit so a
  // single-byte pixel still has a legal vector.
  function automatic int idx_width(input int bytes_per_pix);
    return (bytes_per_pix > 1) ? $clog2(bytes_per_pix) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pix_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pix_fifo
// Description : Synchronous first-word-fall-through FIFO. Head word is
//               presented combinationally; reads as zero when empty.
//               A push into a full FIFO succeeds when a pop happens in the
//               same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             i_clk_sys,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until pointed at by a valid entry
  always_ff @(posedge i_clk_sys) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pix_frame_rcv.sv
`default_nettype none
// ============================================================================
// Module      : pix_frame_rcv
// Description : Framed UART pixel receiver. Hunts for a sync byte, packs
//               BYTES_PER_PIX bytes per pixel for FRAME_PIX pixels, checks a
//               trailing XOR checksum, recovers from idle timeouts and hands
//               pixels out through a small FWFT FIFO with sof/eof tags.
// Revision    : 1.0 - initial release
// ============================================================================
module pix_frame_rcv
  import pix_rx_pkg::*;
#(
  parameter int         PIX_W         = 12,
  parameter int         BYTES_PER_PIX = 2,
  parameter int         FRAME_PIX     = 76800,
  parameter logic [7:0] SYNC_BYTE     = c_DEFAULT_SYNC,
  parameter int         TIMEOUT_CYC   = 50000,
  parameter int         FIFO_DEPTH    = 4
) (
  input  logic             i_clk_sys,
  input  logic             i_rst,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_done,
  output logic [PIX_W-1:0] o_pix,
  output logic             o_pix_valid,
  input  logic             i_pix_ready,
  output logic             o_pix_sof,
  output logic             o_pix_eof,
  output logic             o_frame_done,
  output logic             o_frame_err,
  output logic [7:0]       o_chk
);

  localparam int ACC_W  = 8 * BYTES_PER_PIX;
  localparam int IDX_W  = idx_width(BYTES_PER_PIX);
  localparam int CNT_W  = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYC);
  localparam int FW     = PIX_W + 2;

  localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(BYTES_PER_PIX - 1);
  localparam logic [CNT_W-1:0]  c_LAST_PIX = CNT_W'(FRAME_PIX - 1);
  localparam logic [IDLE_W-1:0] c_IDLE_MAX = IDLE_W'(TIMEOUT_CYC - 1);

  rx_state_t         r_state;
  rx_state_t         w_state_next;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [CNT_W-1:0]  r_pix_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic [7:0]        r_xor;
  logic              r_ovf;
  logic [IDLE_W-1:0] r_idle;
  logic              r_frame_done;
  logic              r_frame_err;
  logic [7:0]        r_chk;

  logic [ACC_W-1:0]  w_acc_next;
  logic [PIX_W-1:0]  w_pix_new;
  logic              w_last_byte;
  logic              w_last_pix;
  logic              w_timeout;
  logic              w_start;
  logic              w_pix_done;
  logic              w_chk_byte;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [FW-1:0]     w_fifo_head;

  // Byte-level datapath helpers; accumulator fills MSB-first
  assign w_acc_next  = (r_acc << 8) | ACC_W'(i_rx_data);
  assign w_pix_new   = w_acc_next[ACC_W-1 -: PIX_W];
  assign w_last_byte = (r_byte_idx == c_LAST_IDX);
  assign w_last_pix  = (r_pix_cnt == c_LAST_PIX);
  // A byte arriving in the expiry cycle wins over the timeout
  assign w_timeout   = (r_state != HUNT) && !i_rx_done && (r_idle == c_IDLE_MAX);

  // FIFO handshake; a same-cycle pop frees room for the push
  assign w_pop  = o_pix_valid && i_pix_ready;
  assign w_push = w_pix_done && (!w_fifo_full || w_pop);
  assign w_drop = w_pix_done && !w_push;

  // Frame state register
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) r_state <= HUNT;
    else       r_state <= w_state_next;
  end

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_pix_done   = 1'b0;
    w_chk_byte   = 1'b0;
    case (r_state)
      HUNT: begin
        if (i_rx_done && (i_rx_data == SYNC_BYTE)) begin
          w_start      = 1'b1;
          w_state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (i_rx_done) begin
          if (w_last_byte) begin
            w_pix_done = 1'b1;
            if (w_last_pix) w_state_next = CHECK;
          end
        end else if (w_timeout) begin
          w_state_next = HUNT;
        end
      end
      CHECK: begin
        if (i_rx_done) begin
          w_chk_byte   = 1'b1;
          w_state_next = HUNT;
        end else if (w_timeout) begin
          w_state_next = HUNT;
        end
      end
      default: w_state_next = HUNT;
    endcase
  end

  // Accumulator, checksum, counters and status pulses
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      r_byte_idx   <= '0;
      r_pix_cnt    <= '0;
      r_acc        <= '0;
      r_xor        <= '0;
      r_ovf        <= 1'b0;
      r_idle       <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_chk        <= '0;
    end else begin
      r_frame_done <= w_chk_byte;
      r_frame_err  <= (w_chk_byte && ((i_rx_data != r_xor) || r_ovf)) || w_timeout;
      if (w_chk_byte || w_timeout) r_chk <= r_xor;

      if (w_start) begin
        r_byte_idx <= '0;
        r_pix_cnt  <= '0;
        r_acc      <= '0;
        r_xor      <= '0;
        r_ovf      <= 1'b0;
      end else if ((r_state == PAYLOAD) && i_rx_done) begin
        r_acc <= w_acc_next;
        r_xor <= r_xor ^ i_rx_data;
        if (w_last_byte) begin
          r_byte_idx <= '0;
          r_pix_cnt  <= w_last_pix ? '0 : r_pix_cnt + 1'b1;
        end else begin
          r_byte_idx <= r_byte_idx + 1'b1;
        end
        if (w_drop) r_ovf <= 1'b1;
      end else if (w_timeout) begin
        r_acc      <= '0;
        r_byte_idx <= '0;
      end

      if ((r_state == HUNT) || i_rx_done || w_timeout) r_idle <= '0;
      else                                             r_idle <= r_idle + 1'b1;
    end
  end

  pix_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk_sys (i_clk_sys),
    .i_rst     (i_rst),
    .i_push    (w_push),
    .i_din     ({w_pix_new, (r_pix_cnt == '0), w_last_pix}),
    .i_pop     (w_pop),
    .o_dout    (w_fifo_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign o_pix        = w_fifo_head[FW-1:2];
  assign o_pix_sof    = w_fifo_head[1];
  assign o_pix_eof    = w_fifo_head[0];
  assign o_pix_valid  = !w_fifo_empty;
  assign o_frame_done = r_frame_done;
  assign o_frame_err  = r_frame_err;
  assign o_chk        = r_chk;

endmodule
`default_nettype wire

// File: tb/tb_pix_frame_rcv.sv
`default_nettype none
// ============================================================================
// Module      : tb_pix_frame_rcv
// Description : Directed self-checking bench for pix_frame_rcv. A second
//               instance with a two-entry FIFO exercises pixel overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pix_frame_rcv;

  logic        r_clk = 1'b0;
  logic        r_rst;
  logic [7:0]  r_rx_data;
  logic        r_rx_done;
  logic        r_rdy;
  logic        r_rdy2;

  logic [11:0] w_pix,  w_pix2;
  logic        w_valid, w_valid2;
  logic        w_sof,  w_sof2;
  logic        w_eof,  w_eof2;
  logic        w_done, w_done2;
  logic        w_err,  w_err2;
  logic [7:0]  w_chk,  w_chk2;

  int n_cmp = 0;
  int n_err = 0;

  logic [13:0] q1[$];
  logic [13:0] q2[$];

  always #5 r_clk = ~r_clk;

  pix_frame_rcv #(
    .PIX_W(12), .BYTES_PER_PIX(2), .FRAME_PIX(4), .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(100), .FIFO_DEPTH(4)
  ) dut (
    .i_clk_sys(r_clk), .i_rst(r_rst), .i_rx_data(r_rx_data), .i_rx_done(r_rx_done),
    .o_pix(w_pix), .o_pix_valid(w_valid), .i_pix_ready(r_rdy),
    .o_pix_sof(w_sof), .o_pix_eof(w_eof), .o_frame_done(w_done),
    .o_frame_err(w_err), .o_chk(w_chk)
  );

  pix_frame_rcv #(
    .PIX_W(12), .BYTES_PER_PIX(2), .FRAME_PIX(4), .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYC(100), .FIFO_DEPTH(2)
  ) dut_ovf (
    .i_clk_sys(r_clk), .i_rst(r_rst), .i_rx_data(r_rx_data), .i_rx_done(r_rx_done),
    .o_pix(w_pix2), .o_pix_valid(w_valid2), .i_pix_ready(r_rdy2),
    .o_pix_sof(w_sof2), .o_pix_eof(w_eof2), .o_frame_done(w_done2),
    .o_frame_err(w_err2), .o_chk(w_chk2)
  );

  // Record every accepted pixel as {pix, sof, eof}
  always @(negedge r_clk) begin
    #1;
    if (w_valid && r_rdy)   q1.push_back({w_pix, w_sof, w_eof});
    if (w_valid2 && r_rdy2) q2.push_back({w_pix2, w_sof2, w_eof2});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle byte strobe; returns on the falling edge after the byte edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge r_clk);
    r_rx_data = b;
    r_rx_done = 1'b1;
    @(negedge r_clk);
    r_rx_done = 1'b0;
  endtask

  task automatic send_payload();
    logic [7:0] pl [8];
    pl = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_byte(8'hA5);
    for (int i = 0; i < 8; i++) send_byte(pl[i]);
  endtask

  // Reference frame: 123(sof) 567 9AB DEF(eof)
  task automatic check_frame_pixels(input string tag);
    logic [13:0] ex [4];
    ex = '{{12'h123, 2'b10}, {12'h567, 2'b00}, {12'h9AB, 2'b00}, {12'hDEF, 2'b01}};
    check({tag, "_count"}, 32'(q1.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < q1.size()) check($sformatf("%s_pix%0d", tag, i), 32'(q1[i]), 32'(ex[i]));
    q1.delete();
  endtask

  initial begin
    r_rst = 1'b1; r_rx_data = 8'h00; r_rx_done = 1'b0; r_rdy = 1'b1; r_rdy2 = 1'b1;
    repeat (3) @(negedge r_clk);

    // Reset state
    check("rst_pix",   32'(w_pix),   0);
    check("rst_valid", 32'(w_valid), 0);
    check("rst_sof",   32'(w_sof),   0);
    check("rst_eof",   32'(w_eof),   0);
    check("rst_done",  32'(w_done),  0);
    check("rst_err",   32'(w_err),   0);
    check("rst_chk",   32'(w_chk),   0);
    r_rst = 1'b0;
    @(negedge r_clk);

    // Good frame; payload XOR of the eight bytes is 00
    send_payload();
    check("s1_lat_valid", 32'(w_valid), 1);
    check("s1_lat_pix",   32'(w_pix),   'hDEF);
    check("s1_lat_eof",   32'(w_eof),   1);
    send_byte(8'h00);
    check("s1_done", 32'(w_done), 1);
    check("s1_err",  32'(w_err),  0);
    check("s1_chk",  32'(w_chk),  'h00);
    @(negedge r_clk);
    check("s1_done_pulse", 32'(w_done), 0);
    repeat (2) @(negedge r_clk);
    check_frame_pixels("s1");

    // Bad checksum byte
    send_payload();
    send_byte(8'h88);
    check("s2_done", 32'(w_done), 1);
    check("s2_err",  32'(w_err),  1);
    check("s2_chk",  32'(w_chk),  'h00);
    repeat (3) @(negedge r_clk);
    check_frame_pixels("s2");

    // Leading junk before sync
    send_byte(8'h00);
    send_byte(8'hFF);
    send_payload();
    send_byte(8'h00);
    check("s3_done", 32'(w_done), 1);
    check("s3_err",  32'(w_err),  0);
    repeat (3) @(negedge r_clk);
    check_frame_pixels("s3");

    // Timeout after three payload bytes; partial XOR 12^34^56 = 70
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    repeat (99) @(negedge r_clk);
    check("s4_err_early", 32'(w_err), 0);
    @(negedge r_clk);
    check("s4_err",  32'(w_err),  1);
    check("s4_done", 32'(w_done), 0);
    check("s4_chk",  32'(w_chk),  'h70);
    @(negedge r_clk);
    check("s4_err_pulse", 32'(w_err), 0);
    check("s4_count", 32'(q1.size()), 1);
    if (q1.size() > 0) check("s4_pix0", 32'(q1[0]), 32'({12'h123, 2'b10}));
    q1.delete();
    send_payload();
    send_byte(8'h00);
    check("s4b_done", 32'(w_done), 1);
    check("s4b_err",  32'(w_err),  0);
    check("s4b_chk",  32'(w_chk),  'h00);
    repeat (3) @(negedge r_clk);
    check_frame_pixels("s4b");

    // Overflow on the two-entry instance with its consumer stalled
    q2.delete();
    r_rdy2 = 1'b0;
    send_payload();
    send_byte(8'h00);
    check("s5_done2", 32'(w_done2), 1);
    check("s5_err2",  32'(w_err2),  1);
    check("s5_err1",  32'(w_err),   0);
    check("s5_valid2", 32'(w_valid2), 1);
    check("s5_head",   32'(w_pix2),   'h123);
    check("s5_sof",    32'(w_sof2),   1);
    repeat (2) @(negedge r_clk);
    check("s5_hold", 32'(w_pix2), 'h123);
    r_rdy2 = 1'b1;
    repeat (3) @(negedge r_clk);
    check("s5_count2", 32'(q2.size()), 2);
    if (q2.size() > 0) check("s5_out0", 32'(q2[0]), 32'({12'h123, 2'b10}));
    if (q2.size() > 1) check("s5_out1", 32'(q2[1]), 32'({12'h567, 2'b00}));
    check("s5_empty2", 32'(w_valid2), 0);
    check_frame_pixels("s5");

    // Reset during the third payload byte flushes a queued pixel
    r_rdy = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    check("s6_queued", 32'(w_valid), 1);
    @(negedge r_clk);
    r_rx_data = 8'h56; r_rx_done = 1'b1; r_rst = 1'b1;
    @(negedge r_clk);
    check("s6_pix",   32'(w_pix),   0);
    check("s6_valid", 32'(w_valid), 0);
    check("s6_sof",   32'(w_sof),   0);
    check("s6_eof",   32'(w_eof),   0);
    check("s6_done",  32'(w_done),  0);
    check("s6_err",   32'(w_err),   0);
    r_rst = 1'b0; r_rx_done = 1'b0; r_rdy = 1'b1;
    q1.delete();
    @(negedge r_clk);
    send_payload();
    send_byte(8'h00);
    check("s6b_done", 32'(w_done), 1);
    check("s6b_err",  32'(w_err),  0);
    repeat (3) @(negedge r_clk);
    check_frame_pixels("s6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
